// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared constants and types for the register file slice.
//   REGFILE_W / REGFILE_N / REGFILE_AW : default word width, register count,
//                                        address width (AW = log2(N))
//   ZERO_REG                           : index of the hard-wired zero register
//   word_t                             : default-width register word
package regfile_pkg;
  localparam int REGFILE_W  = 32;
  localparam int REGFILE_N  = 32;
  localparam int REGFILE_AW = 5;
  localparam int ZERO_REG   = 0;

  typedef logic [REGFILE_W-1:0] word_t;
endpackage

// File: rtl/write_demux_dec.sv
// write_demux_dec
// Write-side demultiplexer decode: turns (wr_en, wr_addr) into a one-hot
// select over N registers. The zero register is never selected, so a write
// to it decodes to all-zeros and is dropped.
// Ports:
//   wr_en   in   write strobe
//   wr_addr in   AW-bit destination index
//   dec     out  N-bit one-hot (or all-zero) register select
module write_demux_dec
  import regfile_pkg::*;
#(
  parameter int N  = REGFILE_N,
  parameter int AW = REGFILE_AW
) (
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  output logic [N-1:0]  dec
);

  always_comb begin
    dec = '0;
    for (int i = 0; i < N; i++) begin
      if (wr_en && (wr_addr == AW'(i))) dec[i] = 1'b1;
    end
    dec[ZERO_REG] = 1'b0;
  end

endmodule

// File: rtl/reg_file_demux.sv
// reg_file_demux
// Register file for the single-cycle datapath: one write port routed through
// a write-side demultiplexer, two asynchronous read ports. Register 0 reads
// as zero and ignores writes.
// Ports:
//   clk       in   clock, all state updates on rising edge
//   reset     in   synchronous active-high reset (clears registers, wr_sel)
//   wr_en     in   write strobe
//   wr_addr   in   destination register index
//   wr_data   in   write-back word
//   rd_addr1  in   read port 1 index
//   rd_addr2  in   read port 2 index
//   rd_data1  out  read port 1 data (combinational)
//   rd_data2  out  read port 2 data (combinational)
//   wr_sel    out  registered one-hot of the write committed at the last edge
// Build option:
//   REGFILE_WRITE_BYPASS_EN  when defined, a read of the register being
//                            written in the same cycle returns wr_data
//                            (write-before-read); otherwise the old contents.
module reg_file_demux
  import regfile_pkg::*;
#(
  parameter int W  = REGFILE_W,
  parameter int N  = REGFILE_N,
  parameter int AW = REGFILE_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic [W-1:0]  rd_data1,
  output logic [W-1:0]  rd_data2,
  output logic [N-1:0]  wr_sel
);

  logic [N-1:0] dec;
  logic [W-1:0] regs [N];
  logic [W-1:0] rd_old1;
  logic [W-1:0] rd_old2;

  write_demux_dec #(
    .N  (N),
    .AW (AW)
  ) u_dec (
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .dec     (dec)
  );

  // ---- write edge: demux select commits one register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
      wr_sel <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (dec[i]) regs[i] <= wr_data;
      end
      wr_sel <= dec;
    end
  end

  // Stored contents; index 0 is forced to zero independently of storage.
  assign rd_old1 = (rd_addr1 == AW'(ZERO_REG)) ? '0 : regs[rd_addr1];
  assign rd_old2 = (rd_addr2 == AW'(ZERO_REG)) ? '0 : regs[rd_addr2];

`ifdef REGFILE_WRITE_BYPASS_EN
  // dec is one-hot on wr_addr (never on 0), so dec[rd_addrK] alone means
  // "this port reads the register being written right now".
  always_comb begin
    if (reset) begin
      rd_data1 = '0;
      rd_data2 = '0;
    end else begin
      rd_data1 = dec[rd_addr1] ? wr_data : rd_old1;
      rd_data2 = dec[rd_addr2] ? wr_data : rd_old2;
    end
  end
`else
  assign rd_data1 = rd_old1;
  assign rd_data2 = rd_old2;
`endif

endmodule

// File: tb/tb_reg_file_demux.sv
module tb_reg_file_demux;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;
  logic [31:0] wr_sel;

  int checks;
  int failures;

  logic [31:0] model [32];

  reg_file_demux #(.W(32), .N(32), .AW(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .wr_sel   (wr_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
    if (a != 5'd0) model[a] = d;
  endtask

  task automatic check_all(input string tag);
    for (int a = 0; a < 32; a++) begin
      rd_addr1 = 5'(a);
      rd_addr2 = 5'(31 - a);
      #1;
      check($sformatf("%s_p1_r%0d", tag, a), rd_data1, model[a]);
      check($sformatf("%s_p2_r%0d", tag, 31 - a), rd_data2, model[31 - a]);
    end
  endtask

  task automatic clear_model();
    for (int a = 0; a < 32; a++) model[a] = 32'h0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear_model();

    // Reset held 2 cycles with a write attempt that must be ignored.
    reset    = 1'b1;
    wr_en    = 1'b1;
    wr_addr  = 5'd5;
    wr_data  = 32'hDEADBEEF;
    rd_addr1 = 5'd0;
    rd_addr2 = 5'd0;
    step();
    step();
    reset = 1'b0;
    wr_en = 1'b0;
    rd_addr1 = 5'd5;
    #1;
    check("reset_r5", rd_data1, 32'h0);
    check("reset_wr_sel", wr_sel, 32'h0);
    check_all("reset_all");

    // Basic write then dual read of the same register.
    write(5'd7, 32'h12345678);
    rd_addr1 = 5'd7;
    rd_addr2 = 5'd7;
    #1;
    check("basic_rd1", rd_data1, 32'h12345678);
    check("basic_rd2", rd_data2, 32'h12345678);
    check("basic_wr_sel", wr_sel, 32'h0000_0080);

    // Write to register 0 is dropped.
    write(5'd0, 32'hFFFFFFFF);
    rd_addr1 = 5'd0;
    #1;
    check("zero_rd1", rd_data1, 32'h0);
    check("zero_wr_sel", wr_sel, 32'h0);

    // Idle cycle clears wr_sel.
    write(5'd6, 32'h00000066);
    check("w6_wr_sel", wr_sel, 32'h0000_0040);
    step();
    check("idle_wr_sel", wr_sel, 32'h0);

    // Same-cycle read/write collision on register 3.
    write(5'd3, 32'hAAAA0000);
    check("coll_pre_wr_sel", wr_sel, 32'h0000_0008);
    wr_en    = 1'b1;
    wr_addr  = 5'd3;
    wr_data  = 32'h0000BBBB;
    rd_addr1 = 5'd3;
    rd_addr2 = 5'd7;
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    check("coll_same_cycle", rd_data1, 32'h0000BBBB);
`else
    check("coll_same_cycle", rd_data1, 32'hAAAA0000);
`endif
    check("coll_other_port", rd_data2, 32'h12345678);
    step();
    wr_en = 1'b0;
    model[3] = 32'h0000BBBB;
    rd_addr2 = 5'd3;
    #1;
    check("coll_next_rd1", rd_data1, 32'h0000BBBB);
    check("coll_next_rd2", rd_data2, 32'h0000BBBB);

    // Back-to-back writes to different registers.
    write(5'd1, 32'd1);
    write(5'd2, 32'd2);
    write(5'd31, 32'd31);
    check("b2b_wr_sel", wr_sel, 32'h8000_0000);
    rd_addr1 = 5'd1;
    rd_addr2 = 5'd31;
    #1;
    check("b2b_r1", rd_data1, 32'd1);
    check("b2b_r31", rd_data2, 32'd31);
    rd_addr1 = 5'd2;
    #1;
    check("b2b_r2", rd_data1, 32'd2);

    // Consecutive writes to one register: last writer wins.
    write(5'd4, 32'h0000_0011);
    write(5'd4, 32'h0000_0022);
    rd_addr1 = 5'd4;
    #1;
    check("lastwin_r4", rd_data1, 32'h0000_0022);
    check_all("full");

    // Reset asserted while writing register 9.
    reset   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 5'd9;
    wr_data = 32'h55;
    step();
    reset = 1'b0;
    wr_en = 1'b0;
    clear_model();
    rd_addr1 = 5'd9;
    #1;
    check("midrst_r9", rd_data1, 32'h0);
    check("midrst_wr_sel", wr_sel, 32'h0);
    check_all("midrst_all");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
